switch_ingress_arb: RTL and testbench

- Ingress stage directly upstream of the address-split switch.
- Merges two independent producer streams, each with a valid/ready handshake, into the switch's single vld/addr/data input.
- Per-input FIFO buffering and a round-robin arbiter.
- At most one beat is presented per cycle. The switch has no backpressure, so this block absorbs all contention.

---
 rtl/switch_ingress_arb.sv | 156 +++++++++++++++
 tb/tb_switch_ingress_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_ingress_arb.sv
// Ingress stage for the address-split switch: two valid/ready producers are
// buffered in per-port FIFOs and merged round-robin onto one registered beat bus.
module switch_ingress_arb #(
    parameter  int ADDR_WIDTH = 8,
    parameter  int DATA_WIDTH = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in0_vld,
    output logic                  in0_rdy,
    input  logic [ADDR_WIDTH-1:0] in0_addr,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in1_vld,
    output logic                  in1_rdy,
    input  logic [ADDR_WIDTH-1:0] in1_addr,
    input  logic [DATA_WIDTH-1:0] in1_data,
    output logic                  vld,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [LVL_W-1:0]      in0_level,
    output logic [LVL_W-1:0]      in1_level
);

    localparam int                NPORT    = 2;
    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                BEAT_W   = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [BEAT_W-1:0] mem       [NPORT][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr    [NPORT];
    logic [PTR_W-1:0]  rd_ptr    [NPORT];
    logic [LVL_W-1:0]  level     [NPORT];
    logic [LVL_W-1:0]  level_nxt [NPORT];
    logic [BEAT_W-1:0] in_beat   [NPORT];

    logic [NPORT-1:0]  in_vld;
    logic [NPORT-1:0]  rdy_q;
    logic [NPORT-1:0]  push;
    logic [NPORT-1:0]  pop;
    logic [NPORT-1:0]  nonempty;

    logic              grant_vld_p0;
    logic              grant_port_p0;
    logic [BEAT_W-1:0] head_p0;

    // Port that wins the next cycle in which both FIFOs hold data.
    logic              prio;

    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    always_comb begin
        in_vld     = {in1_vld, in0_vld};
        in_beat[0] = {in0_addr, in0_data};
        in_beat[1] = {in1_addr, in1_data};
        push       = in_vld & rdy_q;
        for (int p = 0; p < NPORT; p++) begin
            nonempty[p] = (level[p] != '0);
        end
    end

    // Stage p0: grant from current occupancy, pop the winner's head.
    always_comb begin
        grant_vld_p0  = 1'b0;
        grant_port_p0 = 1'b0;
        case (nonempty)
            2'b01: begin
                grant_vld_p0  = 1'b1;
                grant_port_p0 = 1'b0;
            end
            2'b10: begin
                grant_vld_p0  = 1'b1;
                grant_port_p0 = 1'b1;
            end
            2'b11: begin
                grant_vld_p0  = 1'b1;
                grant_port_p0 = prio;
            end
            default: begin
                grant_vld_p0  = 1'b0;
                grant_port_p0 = 1'b0;
            end
        endcase

        pop = '0;
        if (grant_vld_p0) begin
            pop[grant_port_p0] = 1'b1;
        end

        head_p0 = mem[grant_port_p0][rd_ptr[grant_port_p0]];

        for (int p = 0; p < NPORT; p++) begin
            level_nxt[p] = level[p] + LVL_W'(push[p]) - LVL_W'(pop[p]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < NPORT; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                level[p]  <= '0;
            end
            rdy_q   <= '0;
            prio    <= 1'b0;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (push[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                end
                level[p] <= level_nxt[p];
                rdy_q[p] <= (level_nxt[p] != FULL_LVL);
            end

            // Priority only moves when both ports actually competed.
            if (grant_vld_p0 && (&nonempty)) begin
                prio <= ~grant_port_p0;
            end

            // Stage p1: registered beat to the switch, zero when idle.
            vld_p1 <= grant_vld_p0;
            if (grant_vld_p0) begin
                {addr_p1, data_p1} <= head_p0;
            end else begin
                addr_p1 <= '0;
                data_p1 <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (push[p]) begin
                mem[p][wr_ptr[p]] <= in_beat[p];
            end
        end
    end

    assign in0_rdy   = rdy_q[0];
    assign in1_rdy   = rdy_q[1];
    assign vld       = vld_p1;
    assign addr      = addr_p1;
    assign data      = data_p1;
    assign in0_level = level[0];
    assign in1_level = level[1];

endmodule

// File: tb/tb_switch_ingress_arb.sv
// Bench for switch_ingress_arb: directed vector table, corner-case sequences and
// random traffic, all checked against a queue-based model of the ingress stage.
module tb_switch_ingress_arb;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in0_vld, in1_vld;
    logic          in0_rdy, in1_rdy;
    logic [AW-1:0] in0_addr, in1_addr;
    logic [DW-1:0] in0_data, in1_data;
    logic          vld;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [LW-1:0] in0_level, in1_level;

    switch_ingress_arb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in0_vld  (in0_vld),
        .in0_rdy  (in0_rdy),
        .in0_addr (in0_addr),
        .in0_data (in0_data),
        .in1_vld  (in1_vld),
        .in1_rdy  (in1_rdy),
        .in1_addr (in1_addr),
        .in1_data (in1_data),
        .vld      (vld),
        .addr     (addr),
        .data     (data),
        .in0_level(in0_level),
        .in1_level(in1_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          ev;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [LW-1:0] el0;
        logic [LW-1:0] el1;
        logic          er0;
        logic          er1;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: one queue per port, a preferred-port bit for contention.
    logic [AW+DW-1:0] q0[$];
    logic [AW+DW-1:0] q1[$];
    logic             m_rdy0, m_rdy1, m_vld, m_prio;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_rdy0 = 1'b0;
        m_rdy1 = 1'b0;
        m_vld  = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_prio = 1'b0;
    endtask

    task automatic model_edge(input bit a0, input logic [AW+DW-1:0] b0,
                              input bit a1, input logic [AW+DW-1:0] b1);
        logic [AW+DW-1:0] beat;
        bit               have;
        have = 1'b0;
        beat = '0;
        if (q0.size() != 0 && q1.size() != 0) begin
            if (m_prio == 1'b0) beat = q0.pop_front();
            else                beat = q1.pop_front();
            m_prio = ~m_prio;
            have   = 1'b1;
        end else if (q0.size() != 0) begin
            beat = q0.pop_front();
            have = 1'b1;
        end else if (q1.size() != 0) begin
            beat = q1.pop_front();
            have = 1'b1;
        end
        m_vld            = have;
        {m_addr, m_data} = have ? beat : '0;
        if (a0) q0.push_back(b0);
        if (a1) q1.push_back(b1);
        m_rdy0 = (q0.size() != DEPTH);
        m_rdy1 = (q1.size() != DEPTH);
    endtask

    task automatic set_in(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        in0_vld  = v0;
        in0_addr = a0;
        in0_data = d0;
        in1_vld  = v1;
        in1_addr = a1;
        in1_data = d1;
    endtask

    task automatic tick();
        bit               a0, a1;
        logic [AW+DW-1:0] b0, b1;
        a0 = rstn && in0_vld && m_rdy0;
        a1 = rstn && in1_vld && m_rdy1;
        b0 = {in0_addr, in0_data};
        b1 = {in1_addr, in1_data};
        @(posedge clk);
        if (!rstn) model_reset();
        else       model_edge(a0, b0, a1, b1);
        #1;
        check("model_vld",  32'(vld),       32'(m_vld));
        check("model_addr", 32'(addr),      32'(m_addr));
        check("model_data", 32'(data),      32'(m_data));
        check("model_rdy0", 32'(in0_rdy),   32'(m_rdy0));
        check("model_rdy1", 32'(in1_rdy),   32'(m_rdy1));
        check("model_lvl0", 32'(in0_level), 32'(q0.size()));
        check("model_lvl1", 32'(in1_level), 32'(q1.size()));
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_vld"},  32'(vld),       32'd0);
        check({tag, "_addr"}, 32'(addr),      32'd0);
        check({tag, "_data"}, 32'(data),      32'd0);
        check({tag, "_rdy0"}, 32'(in0_rdy),   32'd0);
        check({tag, "_rdy1"}, 32'(in1_rdy),   32'd0);
        check({tag, "_lvl0"}, 32'(in0_level), 32'd0);
        check({tag, "_lvl1"}, 32'(in1_level), 32'd0);
    endtask

    initial begin
        vec_t tbl [11];
        int   port, prev_port, d0, d1, e0, e1, mx0, mx1, got, sent, gaps, hits;
        bit   r0_hi, r0_lo, r1_hi, r1_lo, first, reached, a0, a1, r1_before;
        logic [LW-1:0] lvl_before;

        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        rstn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_state("reset");
        #2 rstn = 1'b1;

        //           v0  a0     d0        v1  a1     d1        ev  ea     ed        l0    l1    r0  r1
        tbl[0]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 8'h10, 16'hABCD, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 3'd1, 3'd0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h10, 16'hABCD, 3'd0, 3'd0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 8'h05, 16'h1111, 1'b1, 8'h80, 16'h2222, 1'b0, 8'h00, 16'h0000, 3'd1, 3'd1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h05, 16'h1111, 3'd0, 3'd1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h80, 16'h2222, 3'd0, 3'd0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 8'h06, 16'h3333, 1'b1, 8'h81, 16'h4444, 1'b0, 8'h00, 16'h0000, 3'd1, 3'd1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h81, 16'h4444, 3'd1, 3'd0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h06, 16'h3333, 3'd0, 3'd0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b1};

        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
            tick();
            check($sformatf("tbl%0d_vld", i),  32'(vld),       32'(tbl[i].ev));
            check($sformatf("tbl%0d_addr", i), 32'(addr),      32'(tbl[i].ea));
            check($sformatf("tbl%0d_data", i), 32'(data),      32'(tbl[i].ed));
            check($sformatf("tbl%0d_lvl0", i), 32'(in0_level), 32'(tbl[i].el0));
            check($sformatf("tbl%0d_lvl1", i), 32'(in1_level), 32'(tbl[i].el1));
            check($sformatf("tbl%0d_rdy0", i), 32'(in0_rdy),   32'(tbl[i].er0));
            check($sformatf("tbl%0d_rdy1", i), 32'(in1_rdy),   32'(tbl[i].er1));
        end

        // Saturation: both ports always valid, data counts up per accepted beat.
        d0 = 0; d1 = 0; e0 = 0; e1 = 0; prev_port = -1; mx0 = 0; mx1 = 0;
        r0_hi = 0; r0_lo = 0; r1_hi = 0; r1_lo = 0;
        for (int c = 0; c < 52; c++) begin
            if (c < 40) set_in(1'b1, 8'h20, 16'(d0), 1'b1, 8'hA0, 16'h8000 + 16'(d1));
            else        set_in(1'b0, 8'h00, 16'h0,   1'b0, 8'h00, 16'h0);
            a0 = in0_vld && m_rdy0;
            a1 = in1_vld && m_rdy1;
            tick();
            if (a0) d0++;
            if (a1) d1++;
            if (vld) begin
                port = (addr == 8'hA0) ? 1 : 0;
                if (port == 0) begin
                    check("sat_order0", 32'(data), 32'(e0));
                    e0++;
                end else begin
                    check("sat_order1", 32'(data), 32'h8000 + 32'(e1));
                    e1++;
                end
                if (c < 40 && prev_port >= 0) check("sat_alternate", 32'(port), 32'(1 - prev_port));
                prev_port = port;
            end
            if (c < 40) begin
                if (32'(in0_level) > mx0) mx0 = 32'(in0_level);
                if (32'(in1_level) > mx1) mx1 = 32'(in1_level);
                if (in0_rdy) r0_hi = 1; else r0_lo = 1;
                if (in1_rdy) r1_hi = 1; else r1_lo = 1;
            end
        end
        check("sat_count0",   32'(e0), 32'(d0));
        check("sat_count1",   32'(e1), 32'(d1));
        check("sat_total",    32'(d0 + d1) >= 32'd36 ? 32'd1 : 32'd0, 32'd1);
        check("sat_max_lvl0", 32'(mx0), 32'(DEPTH));
        check("sat_max_lvl1", 32'(mx1), 32'(DEPTH));
        check("sat_rdy0_toggle", {30'd0, r0_hi, r0_lo}, 32'd3);
        check("sat_rdy1_toggle", {30'd0, r1_hi, r1_lo}, 32'd3);

        // Wrap-around: 3*DEPTH+1 beats on port 0 only.
        sent = 0; got = 0; gaps = 0; mx0 = 0; first = 0;
        for (int c = 0; c < 30; c++) begin
            set_in(sent < 13, 8'h33, 16'(sent), 1'b0, 8'h00, 16'h0);
            a0 = in0_vld && m_rdy0;
            tick();
            if (a0) sent++;
            if (vld) begin
                check("wrap_data", 32'(data), 32'(got));
                got++;
                first = 1;
            end else if (first && got < 13) begin
                gaps++;
            end
            if (32'(in0_level) > mx0) mx0 = 32'(in0_level);
        end
        check("wrap_count",   32'(got),  32'd13);
        check("wrap_gaps",    32'(gaps), 32'd0);
        check("wrap_max_lvl", 32'(mx0),  32'd1);

        // Full boundary on port 1 while port 0 streams.
        mx1 = 0; hits = 0;
        for (int c = 0; c < 28; c++) begin
            set_in(c < 16, 8'h44, 16'(c), c < 12, 8'hB4, 16'h0B00 + 16'(c));
            r1_before  = in1_rdy;
            lvl_before = in1_level;
            tick();
            if (32'(in1_level) > mx1) mx1 = 32'(in1_level);
            if (in1_level == LW'(DEPTH)) begin
                hits++;
                check("full_rdy_low", 32'(in1_rdy), 32'd0);
            end
            if (!r1_before && c < 12)
                check("full_no_write", (in1_level <= lvl_before) ? 32'd1 : 32'd0, 32'd1);
        end
        check("full_max_lvl1", 32'(mx1), 32'(DEPTH));
        check("full_hit",      (hits > 0) ? 32'd1 : 32'd0, 32'd1);

        // Asynchronous reset with both FIFOs holding three beats.
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            set_in(1'b1, 8'h55, 16'h5500 + 16'(c), 1'b1, 8'hC5, 16'hC500 + 16'(c));
            tick();
            reached = (q0.size() == 3 && q1.size() == 3);
        end
        check("rst_pre_lvl0", 32'(in0_level), 32'd3);
        check("rst_pre_lvl1", 32'(in1_level), 32'd3);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_zero_state("async_rst");
        tick();
        #2 rstn = 1'b1;
        set_in(1'b0, 8'h00, 16'h0, 1'b0, 8'h00, 16'h0);
        tick();
        check("rel_rdy0", 32'(in0_rdy), 32'd1);
        check("rel_rdy1", 32'(in1_rdy), 32'd1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("rel_no_stale", 32'(vld), 32'd0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 3) != 0, 8'($urandom), 16'($urandom),
                   $urandom_range(0, 1) == 1, 8'($urandom), 16'($urandom));
            tick();
        end
        set_in(1'b0, 8'h00, 16'h0, 1'b0, 8'h00, 16'h0);
        repeat (12) tick();
        check("final_lvl0", 32'(in0_level), 32'd0);
        check("final_lvl1", 32'(in1_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
